mac_layer_stream: RTL and testbench

- Next-generation, fully parametrised dense neural-network layer.
- Captures one input activation vector through a valid/ready handshake, then time-multiplexes PARALLEL_MACS signed multipliers across OUT_WIDTH neurons.
- Adds a per-neuron bias to each accumulated sum and emits either a binary (sign) vector or a ReLU-saturated multi-bit vector through a second valid/ready handshake.
- Weight and bias memories are runtime-writable. The block chains between hidden layers of the MLP/BNN pipeline.

---
 rtl/mac_layer_pkg.sv | 44 ++++
 rtl/mac_layer_stream_mac_tree.sv | 31 +++
 rtl/mac_layer_stream.sv | 181 ++++++++++++++++++
 tb/tb_mac_layer_stream.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_layer_pkg.sv
// Shared types and arithmetic helpers for the streaming dense layer.
package mac_layer_pkg;

  // Widest intermediate used by the sign-extension and saturation helpers.
  localparam int unsigned MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  // Accumulator width that cannot overflow for a full dot product plus bias.
  function automatic int unsigned acc_width(input int unsigned act_bits,
                                            input int unsigned w_bits,
                                            input int unsigned in_width);
    return act_bits + w_bits + int'($clog2(in_width)) + 2;
  endfunction

  // Sign-extend the low 'bits' bits of v to MAX_W.
  function automatic logic signed [MAX_W-1:0] sext(input logic [MAX_W-1:0] v,
                                                   input int unsigned    bits);
    logic signed [MAX_W-1:0] t;
    t = $signed(v << (MAX_W - bits));
    return t >>> (MAX_W - bits);
  endfunction

  // Arithmetic shift, then clamp to [0, 2^(act_bits-1)-1].
  function automatic logic [MAX_W-1:0] relu_sat(input logic signed [MAX_W-1:0] sum,
                                                input int unsigned           shift,
                                                input int unsigned           act_bits);
    logic signed [MAX_W-1:0] v;
    logic signed [MAX_W-1:0] max_v;
    v     = sum >>> shift;
    max_v = (64'sd1 <<< (act_bits - 1)) - 64'sd1;
    if (v < 64'sd0) begin
      return '0;
    end else if (v > max_v) begin
      return max_v;
    end
    return v;
  endfunction

endpackage

// File: rtl/mac_layer_stream_mac_tree.sv
// Combinational signed multiply + adder tree over PARALLEL_MACS lanes.
module mac_tree #(
  parameter int unsigned PARALLEL_MACS = 32,
  parameter int unsigned ACT_BITS      = 8,
  parameter int unsigned W_BITS        = 8,
  parameter int unsigned ACC_WIDTH     = 26
) (
  input  logic [PARALLEL_MACS*ACT_BITS-1:0] act,
  input  logic [PARALLEL_MACS*W_BITS-1:0]   wgt,
  output logic [ACC_WIDTH-1:0]              partial_sum_c
);

  localparam int unsigned PROD_W = ACT_BITS + W_BITS;

  logic signed [PROD_W-1:0] prod [PARALLEL_MACS];

  // One signed multiplier per lane.
  for (genvar i = 0; i < PARALLEL_MACS; i++) begin : g_lane
    assign prod[i] = $signed(act[i*ACT_BITS +: ACT_BITS]) * $signed(wgt[i*W_BITS +: W_BITS]);
  end

  // Sign-extend each product and reduce to one partial sum.
  always_comb begin
    partial_sum_c = '0;
    for (int i = 0; i < PARALLEL_MACS; i++) begin
      partial_sum_c = partial_sum_c +
                      {{(ACC_WIDTH-PROD_W){prod[i][PROD_W-1]}}, prod[i]};
    end
  end

endmodule

// File: rtl/mac_layer_stream.sv
// Streaming dense layer: capture one activation vector, time-multiplex the
// MAC tree across all neurons, add bias, emit sign or ReLU-saturated outputs.
module mac_layer_stream
  import mac_layer_pkg::*;
#(
  parameter int unsigned IN_WIDTH      = 256,
  parameter int unsigned OUT_WIDTH     = 128,
  parameter int unsigned PARALLEL_MACS = 32,
  parameter int unsigned ACT_BITS      = 8,
  parameter int unsigned W_BITS        = 8,
  parameter int unsigned BIAS_BITS     = 16,
  parameter int unsigned OUT_MODE      = 0,
  parameter int unsigned SHIFT         = 0
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic                                                   in_valid,
  output logic                                                   in_ready,
  input  logic [IN_WIDTH*ACT_BITS-1:0]                           in_data,
  input  logic                                                   w_wr_en,
  input  logic [((OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1)-1:0]   w_wr_neuron,
  input  logic [(((IN_WIDTH/PARALLEL_MACS) > 1) ?
                 $clog2(IN_WIDTH/PARALLEL_MACS) : 1)-1:0]        w_wr_chunk,
  input  logic [PARALLEL_MACS*W_BITS-1:0]                        w_wr_data,
  input  logic                                                   b_wr_en,
  input  logic [((OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1)-1:0]   b_wr_neuron,
  input  logic [BIAS_BITS-1:0]                                   b_wr_data,
  output logic                                                   out_valid,
  input  logic                                                   out_ready,
  output logic [OUT_WIDTH*((OUT_MODE != 0) ? ACT_BITS : 1)-1:0]  out_data,
  output logic                                                   busy,
  output logic                                                   wr_err
);

  localparam int unsigned CHUNKS     = IN_WIDTH / PARALLEL_MACS;
  localparam int unsigned ACC_WIDTH  = acc_width(ACT_BITS, W_BITS, IN_WIDTH);
  localparam int unsigned OBITS      = (OUT_MODE != 0) ? ACT_BITS : 1;
  localparam int unsigned NEURON_W   = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
  localparam int unsigned CHUNK_W    = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int unsigned CHUNK_BITS = PARALLEL_MACS * ACT_BITS;
  localparam int unsigned WROW_BITS  = PARALLEL_MACS * W_BITS;

  localparam logic [CHUNK_W-1:0]  LAST_CHUNK  = CHUNK_W'(CHUNKS - 1);
  localparam logic [NEURON_W-1:0] LAST_NEURON = NEURON_W'(OUT_WIDTH - 1);

  // Reject configurations where the input vector does not split into whole chunks.
  if (IN_WIDTH % PARALLEL_MACS != 0) begin : g_bad_parallel
    $error("mac_layer_stream: IN_WIDTH must be a multiple of PARALLEL_MACS");
  end

  state_t                 state;
  logic [NEURON_W-1:0]    neuron;
  logic [CHUNK_W-1:0]     chunk;
  logic [ACC_WIDTH-1:0]   acc;
  logic [OBITS-1:0]       out_slot [OUT_WIDTH];

  // Storage that intentionally survives reset.
  logic [WROW_BITS-1:0]    w_mem  [OUT_WIDTH][CHUNKS];
  logic [BIAS_BITS-1:0]    b_mem  [OUT_WIDTH];
  logic [IN_WIDTH*ACT_BITS-1:0] in_buf;
  logic [CHUNK_BITS-1:0]   in_chunks [CHUNKS];

  logic                    in_fire_c;
  logic                    wr_open_c;
  logic [ACC_WIDTH-1:0]    bias_ext_c;
  logic [ACC_WIDTH-1:0]    base_c;
  logic [ACC_WIDTH-1:0]    partial_sum_c;
  logic [ACC_WIDTH-1:0]    final_sum_c;
  logic [MAX_W-1:0]        relu_c;
  logic [OBITS-1:0]        neuron_out_c;

  assign in_fire_c = (state == IDLE) && in_valid && in_ready;
  assign wr_open_c = (state != COMPUTE);

  // Chunk view of the captured activation vector.
  for (genvar c = 0; c < CHUNKS; c++) begin : g_chunk
    assign in_chunks[c] = in_buf[c*CHUNK_BITS +: CHUNK_BITS];
  end

  // Pack per-neuron result registers onto the output bus.
  for (genvar n = 0; n < OUT_WIDTH; n++) begin : g_out
    assign out_data[n*OBITS +: OBITS] = out_slot[n];
  end

  mac_tree #(
    .PARALLEL_MACS (PARALLEL_MACS),
    .ACT_BITS      (ACT_BITS),
    .W_BITS        (W_BITS),
    .ACC_WIDTH     (ACC_WIDTH)
  ) u_mac_tree (
    .act           (in_chunks[chunk]),
    .wgt           (w_mem[neuron][chunk]),
    .partial_sum_c (partial_sum_c)
  );

  // Bias seeds the accumulator at chunk 0; neuron result is formed on the last chunk.
  always_comb begin
    bias_ext_c   = ACC_WIDTH'(sext(MAX_W'(b_mem[neuron]), BIAS_BITS));
    base_c       = (chunk == '0) ? bias_ext_c : acc;
    final_sum_c  = base_c + partial_sum_c;
    relu_c       = relu_sat(sext(MAX_W'(final_sum_c), ACC_WIDTH), SHIFT, ACT_BITS);
    neuron_out_c = '0;
    if (OUT_MODE != 0) begin
      neuron_out_c = OBITS'(relu_c);
    end else begin
      neuron_out_c = OBITS'(~final_sum_c[ACC_WIDTH-1]);
    end
  end

  // Runtime-writable weights/bias and input capture; writes are closed during COMPUTE.
  always_ff @(posedge clk) begin
    if (w_wr_en && wr_open_c) begin
      w_mem[w_wr_neuron][w_wr_chunk] <= w_wr_data;
    end
    if (b_wr_en && wr_open_c) begin
      b_mem[b_wr_neuron] <= b_wr_data;
    end
    if (in_fire_c) begin
      in_buf <= in_data;
    end
  end

  // Frame control: IDLE accepts a vector, COMPUTE walks neurons x chunks, HOLD presents the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      wr_err    <= 1'b0;
      neuron    <= '0;
      chunk     <= '0;
      acc       <= '0;
      for (int n = 0; n < OUT_WIDTH; n++) begin
        out_slot[n] <= '0;
      end
    end else begin
      wr_err <= (state == COMPUTE) && (w_wr_en || b_wr_en);
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_fire_c) begin
            in_ready <= 1'b0;
            neuron   <= '0;
            chunk    <= '0;
            busy     <= 1'b1;
            state    <= COMPUTE;
          end
        end
        COMPUTE: begin
          acc <= final_sum_c;
          if (chunk == LAST_CHUNK) begin
            out_slot[neuron] <= neuron_out_c;
            chunk            <= '0;
            if (neuron == LAST_NEURON) begin
              neuron    <= '0;
              busy      <= 1'b0;
              out_valid <= 1'b1;
              state     <= HOLD;
            end else begin
              neuron <= neuron + NEURON_W'(1);
            end
          end else begin
            chunk <= chunk + CHUNK_W'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_layer_stream.sv
// Bench for mac_layer_stream: three instances (sign, ReLU, ReLU with shift)
// share one stimulus stream and are checked against an integer model.
module tb_mac_layer_stream;

  localparam int IN_W  = 8;
  localparam int OUT_W = 4;
  localparam int PM    = 2;
  localparam int NCH   = IN_W / PM;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [63:0] in_data;
  logic        w_wr_en;
  logic [1:0]  w_wr_neuron;
  logic [1:0]  w_wr_chunk;
  logic [15:0] w_wr_data;
  logic        b_wr_en;
  logic [1:0]  b_wr_neuron;
  logic [15:0] b_wr_data;
  logic        out_ready;

  logic        in_ready_b, out_valid_b, busy_b, wr_err_b;
  logic        in_ready_r, out_valid_r, busy_r, wr_err_r;
  logic        in_ready_s, out_valid_s, busy_s, wr_err_s;
  logic [3:0]  out_data_b;
  logic [31:0] out_data_r;
  logic [31:0] out_data_s;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  int hs_cyc = 0;

  // Reference model state
  int          xm [IN_W];
  int          wm [OUT_W][IN_W];
  int          bm [OUT_W];
  logic [3:0]  exp_bin;
  logic [31:0] exp_relu;
  logic [31:0] exp_sh;

  mac_layer_stream #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .PARALLEL_MACS(PM), .ACT_BITS(8),
                     .W_BITS(8), .BIAS_BITS(16), .OUT_MODE(0), .SHIFT(0)) dut_bin (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .w_wr_en(w_wr_en), .w_wr_neuron(w_wr_neuron), .w_wr_chunk(w_wr_chunk), .w_wr_data(w_wr_data),
    .b_wr_en(b_wr_en), .b_wr_neuron(b_wr_neuron), .b_wr_data(b_wr_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .busy(busy_b), .wr_err(wr_err_b));

  mac_layer_stream #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .PARALLEL_MACS(PM), .ACT_BITS(8),
                     .W_BITS(8), .BIAS_BITS(16), .OUT_MODE(1), .SHIFT(0)) dut_relu (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_r), .in_data(in_data),
    .w_wr_en(w_wr_en), .w_wr_neuron(w_wr_neuron), .w_wr_chunk(w_wr_chunk), .w_wr_data(w_wr_data),
    .b_wr_en(b_wr_en), .b_wr_neuron(b_wr_neuron), .b_wr_data(b_wr_data),
    .out_valid(out_valid_r), .out_ready(out_ready), .out_data(out_data_r),
    .busy(busy_r), .wr_err(wr_err_r));

  mac_layer_stream #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .PARALLEL_MACS(PM), .ACT_BITS(8),
                     .W_BITS(8), .BIAS_BITS(16), .OUT_MODE(1), .SHIFT(2)) dut_sh (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .w_wr_en(w_wr_en), .w_wr_neuron(w_wr_neuron), .w_wr_chunk(w_wr_chunk), .w_wr_data(w_wr_data),
    .b_wr_en(b_wr_en), .b_wr_neuron(b_wr_neuron), .b_wr_data(b_wr_data),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
    .busy(busy_s), .wr_err(wr_err_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Hard stop in case the sequence wedges somewhere unbounded.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Control outputs of all three instances against one expected tuple.
  task automatic chk_status(input string tag, input bit ir, input bit ov, input bit bz, input bit we);
    chk(tag, {52'd0, in_ready_b, out_valid_b, busy_b, wr_err_b,
                     in_ready_r, out_valid_r, busy_r, wr_err_r,
                     in_ready_s, out_valid_s, busy_s, wr_err_s},
             {52'd0, {3{ir, ov, bz, we}}});
  endtask

  function automatic int clamp127(input int v);
    if (v < 0) return 0;
    if (v > 127) return 127;
    return v;
  endfunction

  // Dense layer from first principles: dot product plus bias per neuron.
  task automatic compute_expect();
    int s;
    for (int n = 0; n < OUT_W; n++) begin
      s = bm[n];
      for (int j = 0; j < IN_W; j++) s += xm[j] * wm[n][j];
      exp_bin[n]          = (s >= 0);
      exp_relu[n*8 +: 8]  = 8'(clamp127(s));
      exp_sh[n*8 +: 8]    = 8'(clamp127(s >>> 2));
    end
  endtask

  task automatic write_both(input int n, input int c, input int w0, input int w1,
                            input bit do_b, input int b, input bit upd);
    w_wr_en     = 1'b1;
    w_wr_neuron = 2'(n);
    w_wr_chunk  = 2'(c);
    w_wr_data   = {8'(w1), 8'(w0)};
    b_wr_en     = do_b;
    b_wr_neuron = 2'(n);
    b_wr_data   = 16'(b);
    @(negedge clk);
    w_wr_en = 1'b0;
    b_wr_en = 1'b0;
    if (upd) begin
      wm[n][c*PM]   = w0;
      wm[n][c*PM+1] = w1;
      if (do_b) bm[n] = b;
    end
  endtask

  task automatic set_all_w(input int v);
    for (int n = 0; n < OUT_W; n++)
      for (int c = 0; c < NCH; c++) write_both(n, c, v, v, 1'b0, 0, 1'b1);
  endtask

  task automatic set_bias(input int n, input int v);
    b_wr_en     = 1'b1;
    b_wr_neuron = 2'(n);
    b_wr_data   = 16'(v);
    @(negedge clk);
    b_wr_en = 1'b0;
    bm[n]   = v;
  endtask

  task automatic set_all_x(input int v);
    for (int j = 0; j < IN_W; j++) xm[j] = v;
  endtask

  // Input handshake; returns at the falling edge after the accepting edge.
  task automatic start_frame();
    for (int i = 0; i < 50 && !in_ready_b; i++) @(negedge clk);
    chk("in_ready_wait", 64'(in_ready_b), 64'd1);
    for (int j = 0; j < IN_W; j++) in_data[j*8 +: 8] = 8'(xm[j]);
    in_valid = 1'b1;
    compute_expect();
    @(posedge clk);
    @(negedge clk);
    hs_cyc   = cyc_cnt;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    for (int i = 0; i < 100 && !out_valid_b; i++) @(negedge clk);
    chk({tag, "_latency"}, 64'(cyc_cnt - hs_cyc), 64'd16);
    chk({tag, "_valid"}, {61'd0, out_valid_b, out_valid_r, out_valid_s}, 64'd7);
    chk({tag, "_bin"}, 64'(out_data_b), 64'(exp_bin));
    chk({tag, "_relu"}, 64'(out_data_r), 64'(exp_relu));
    chk({tag, "_relu_sh"}, 64'(out_data_s), 64'(exp_sh));
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk_status("after_drain", 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    w_wr_en = 1'b0; w_wr_neuron = '0; w_wr_chunk = '0; w_wr_data = '0;
    b_wr_en = 1'b0; b_wr_neuron = '0; b_wr_data = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk_status("reset_status", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_data", {out_data_s, out_data_r}, 64'd0);
    chk("reset_data_bin", 64'(out_data_b), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk_status("ready_after_reset", 1'b1, 1'b0, 1'b0, 1'b0);

    // 1: all +1, inputs 1, bias 0; out_ready without out_valid is harmless
    set_all_w(1);
    for (int n = 0; n < OUT_W; n++) set_bias(n, 0);
    set_all_x(1);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_status("idle_out_ready", 1'b1, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    start_frame();
    chk_status("compute_status", 1'b0, 1'b0, 1'b1, 1'b0);
    wait_out("s1");
    chk("s1_bin_const", 64'(out_data_b), 64'hF);
    drain();

    // 2: neuron 2 negative, then bias rescues it to exactly zero
    for (int c = 0; c < NCH; c++) write_both(2, c, -1, -1, 1'b0, 0, 1'b1);
    start_frame();
    wait_out("s2a");
    chk("s2a_bin_const", 64'(out_data_b), 64'hB);
    drain();
    set_bias(2, 8);
    start_frame();
    wait_out("s2b");
    chk("s2b_bin_const", 64'(out_data_b), 64'hF);
    drain();

    // 3: ReLU cases
    set_all_w(2);
    for (int n = 0; n < OUT_W; n++) set_bias(n, 1);
    set_all_x(3);
    start_frame();
    wait_out("s3_49");
    chk("s3_49_const", 64'(out_data_r[7:0]), 64'd49);
    chk("s3_12_const", 64'(out_data_s[7:0]), 64'd12);
    drain();
    set_all_w(127);
    set_all_x(127);
    start_frame();
    wait_out("s3_sat");
    drain();
    set_all_w(-1);
    start_frame();
    wait_out("s3_neg");
    drain();

    // 4: back-pressure in HOLD with an ignored in_valid pulse
    for (int n = 0; n < OUT_W; n++)
      for (int c = 0; c < NCH; c++)
        write_both(n, c, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                   1'b1, int'($urandom_range(0, 4000)) - 2000, 1'b1);
    for (int j = 0; j < IN_W; j++) xm[j] = int'($urandom_range(0, 255)) - 128;
    start_frame();
    wait_out("s4");
    for (int k = 0; k < 10; k++) begin
      in_valid = (k == 3);
      if (k == 3) in_data = {$urandom, $urandom};
      @(negedge clk);
      chk("s4_hold_bin", 64'(out_data_b), 64'(exp_bin));
      chk("s4_hold_relu", {out_data_s, out_data_r}, {exp_sh, exp_relu});
      chk_status("s4_hold_status", 1'b0, 1'b1, 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    drain();

    // Randomised frames with full-range weights and biases
    for (int f = 0; f < 6; f++) begin
      for (int n = 0; n < OUT_W; n++)
        for (int c = 0; c < NCH; c++)
          write_both(n, c, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                     1'b1, int'($urandom_range(0, 65535)) - 32768, 1'b1);
      for (int j = 0; j < IN_W; j++) xm[j] = int'($urandom_range(0, 255)) - 128;
      start_frame();
      wait_out("rand");
      drain();
    end

    // 5: writes during COMPUTE are dropped; same writes in HOLD land next frame
    start_frame();
    @(negedge clk);
    write_both(0, 0, 55, -77, 1'b1, 1234, 1'b0);
    chk_status("s5_wr_err_pulse", 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk_status("s5_wr_err_clear", 1'b0, 1'b0, 1'b1, 1'b0);
    wait_out("s5_old");
    write_both(0, 0, 55, -77, 1'b1, 1234, 1'b1);
    chk_status("s5_hold_write", 1'b0, 1'b1, 1'b0, 1'b0);
    drain();
    start_frame();
    wait_out("s5_new");
    drain();

    // 6: reset mid-COMPUTE aborts; retained weights give scenario-1 result
    set_all_w(1);
    for (int n = 0; n < OUT_W; n++) set_bias(n, 0);
    set_all_x(1);
    start_frame();
    repeat (7) @(negedge clk);
    reset = 1'b1;
    #1;
    chk_status("s6_abort_status", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("s6_abort_data", {out_data_s, out_data_r}, 64'd0);
    chk("s6_abort_bin", 64'(out_data_b), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_status("s6_ready", 1'b1, 1'b0, 1'b0, 1'b0);
    start_frame();
    wait_out("s6");
    chk("s6_bin_const", 64'(out_data_b), 64'hF);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
